usb_transaction_sequencer: RTL and testbench
============================================

// Module: usb_transaction_sequencer
// PURPOSE
//  Full-speed USB device protocol engine between the packet receiver/transmitter and the CPU endpoint buffers.
//  Consumes decoded tokens and data-packet results, then selects the handshake or DATA PID the transmitter sends.
//  Owns per-endpoint DATA0/DATA1 toggles, the device-address match and the bus turnaround timeout.
//  Reports completed SETUP/OUT/IN transactions to software via one-cycle event pulses.
// PARAMETERS
//  NUM_ENDPOINTS    4   endpoints implemented (1..16); tokens to higher endpoints are ignored
//  TIMEOUT_CYCLES   72  clock48 cycles to wait for the host's DATA/ACK (18 bit times at 4 clk/bit)
// PORTS
//  clock48            in   1   48 MHz clock; the only clock
//  reset_n            in   1   asynchronous, active-low reset
//  device_address     in   7   address assigned by software; 0 after bus reset
//  rx_token_valid     in   1   1-cycle pulse: token packet decoded, CRC5 good
//  rx_pid             in   4   PID of the packet flagged by rx_token_valid or rx_data_valid
//  rx_token_address   in   7   ADDR field of token
//  rx_token_endpoint  in   4   ENDP field of token
//  rx_data_valid      in   1   1-cycle pulse at EOP of a DATA0/DATA1 or handshake packet
//  rx_data_ok         in   1   CRC16 good; sampled with rx_data_valid
//  tx_start           out  1   1-cycle pulse: transmitter sends tx_pid (+ IN buffer if tx_with_data)
//  tx_pid             out  4   PID to transmit; held stable from tx_start until tx_done
//  tx_with_data       out  1   1 = data packet from IN buffer of current_endpoint, 0 = handshake
//  tx_done            in   1   1-cycle pulse: transmitter finished EOP
//  ep_in_ready        in   NE  software has loaded the IN buffer of endpoint n
//  ep_out_free        in   NE  OUT/SETUP buffer of endpoint n can accept a packet
//  ep_stall           in   NE  endpoint n halted
//  current_endpoint   out  4   endpoint of the transaction in progress
//  setup_received     out  1   1-cycle pulse: SETUP data accepted on current_endpoint
//  out_received       out  1   1-cycle pulse: new OUT data accepted on current_endpoint
//  in_sent            out  1   1-cycle pulse: IN data ACKed by host on current_endpoint
// BEHAVIOUR
//  Reset: state IDLE; all tx_*/event outputs 0; current_endpoint 0; all toggles DATA0; timer 0.
//  States: IDLE, WAIT_DATA, SEND_HANDSHAKE, SEND_DATA, WAIT_ACK, WAIT_TX.
//  IDLE: on rx_token_valid with address==device_address and endpoint<NUM_ENDPOINTS:
//   SETUP/OUT -> WAIT_DATA (latch endpoint, timer cleared); IN -> SEND_DATA or SEND_HANDSHAKE.
//   Other PIDs, address mismatch or endpoint out of range: stay IDLE, no output.
//  WAIT_DATA: timer counts; at TIMEOUT_CYCLES -> IDLE silently. rx_data_valid with !rx_data_ok -> IDLE silently.
//   SETUP + good DATA0: always ACK (even if stalled/not free); clears stall handling for this transaction;
//    sets out toggle to DATA1 and in toggle to DATA1; pulse setup_received.
//   OUT + good data: ep_stall -> STALL; !ep_out_free -> NAK; PID==expected toggle -> ACK, flip toggle,
//    pulse out_received; PID!=toggle -> ACK, no flip, no pulse (retransmission discard).
//  IN: ep_stall -> STALL; !ep_in_ready -> NAK; else tx_pid = in toggle (DATA0/DATA1), tx_with_data=1 -> WAIT_ACK.
//  tx_start asserted exactly one cycle after the decision; then WAIT_TX until tx_done -> IDLE.
//  WAIT_ACK: after tx_done, timer restarts; rx_data_valid with PID ACK -> flip in toggle, pulse in_sent, IDLE;
//   any other packet or timeout -> IDLE, toggle unchanged (host will retry).
//  Event pulses fire the cycle the decision is made; never two events in one cycle.
//  rx_token_valid arriving outside IDLE/WAIT_DATA is ignored; in WAIT_DATA a new token aborts and restarts as IDLE would.
//  device_address change takes effect on the next token only.
//  Timer saturates at TIMEOUT_CYCLES; width = $clog2(TIMEOUT_CYCLES+1).
//  reset_n low mid-transaction: abort immediately, tx_start never re-issued, toggles to DATA0.
// CONFIGURATION
//  USB_SEQ_STALL_EN defined: ep_stall honoured as above (STALL on OUT/IN, SETUP overrides).
//  Not defined: ep_stall ignored, STALL PID never generated; NAK/ACK rules otherwise identical.
// TESTING
//  addr=0, SETUP ep0 + good DATA0 -> tx_pid=ACK, setup_received 1 cycle, in toggle=DATA1.
//  After SETUP, IN ep0 with ep_in_ready=1 -> tx_pid=DATA1, tx_with_data=1; host ACK -> in_sent, next IN sends DATA0.
//  OUT ep1 DATA0 twice, ep_out_free=1 -> both ACK; out_received only on first; expected toggle DATA1.
//  IN ep2 with ep_in_ready=0 -> NAK; token addr=5 when device_address=1 -> no tx_start.
//  OUT ep1 token, no data for 72 cycles -> back to IDLE, no tx_start; bad CRC data -> no response.
//  USB_SEQ_STALL_EN set, ep_stall[1]=1: IN ep1 -> STALL; SETUP ep1 -> ACK; undefined -> IN ep1 -> DATA0.

Source files
------------

// File: rtl/usb_transaction_sequencer_if.sv
// rtl/usb_transaction_sequencer_if.sv - packet rx/tx and endpoint-buffer signals of the USB transaction sequencer
interface usb_transaction_sequencer_if #(
    parameter int NE = 4
) ();
    logic [6:0]    device_address;
    logic          rx_token_valid;
    logic [3:0]    rx_pid;
    logic [6:0]    rx_token_address;
    logic [3:0]    rx_token_endpoint;
    logic          rx_data_valid;
    logic          rx_data_ok;
    logic          tx_start;
    logic [3:0]    tx_pid;
    logic          tx_with_data;
    logic          tx_done;
    logic [NE-1:0] ep_in_ready;
    logic [NE-1:0] ep_out_free;
    logic [NE-1:0] ep_stall;
    logic [3:0]    current_endpoint;
    logic          setup_received;
    logic          out_received;
    logic          in_sent;

    modport master (
        input  device_address, rx_token_valid, rx_pid, rx_token_address, rx_token_endpoint,
        input  rx_data_valid, rx_data_ok, tx_done, ep_in_ready, ep_out_free, ep_stall,
        output tx_start, tx_pid, tx_with_data, current_endpoint,
        output setup_received, out_received, in_sent
    );

    modport slave (
        output device_address, rx_token_valid, rx_pid, rx_token_address, rx_token_endpoint,
        output rx_data_valid, rx_data_ok, tx_done, ep_in_ready, ep_out_free, ep_stall,
        input  tx_start, tx_pid, tx_with_data, current_endpoint,
        input  setup_received, out_received, in_sent
    );
endinterface

// File: rtl/usb_transaction_sequencer.sv
// rtl/usb_transaction_sequencer.sv - full-speed USB device transaction engine (STALL support via USB_SEQ_STALL_EN)
module usb_transaction_sequencer #(
    parameter int NUM_ENDPOINTS  = 4,
    parameter int TIMEOUT_CYCLES = 72
) (
    input logic                     clock48,
    input logic                     reset_n,
    usb_transaction_sequencer_if.master bus
);
    localparam int EPW = (NUM_ENDPOINTS > 1) ? $clog2(NUM_ENDPOINTS) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [4:0]    EP_LIMIT = 5'(NUM_ENDPOINTS);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        IDLE, WAIT_DATA, SEND_HANDSHAKE, SEND_DATA, WAIT_ACK, WAIT_TX
    } state_t;

    state_t                   state, state_next;
    logic [TW-1:0]            timer, timer_next;
    logic [3:0]               ep_reg, ep_next;
    logic                     is_setup, is_setup_next;
    logic [3:0]               tx_pid_reg, tx_pid_next;
    logic                     with_data, with_data_next;
    logic [NUM_ENDPOINTS-1:0] in_toggle, in_toggle_next;
    logic [NUM_ENDPOINTS-1:0] out_toggle, out_toggle_next;

    logic           resp_valid, resp_data;
    logic [3:0]     resp_pid;
    logic           tx_start_c, setup_ev, out_ev, in_ev;
    logic           token_hit, rx_is_data, tok_stall, cur_stall;
    logic [EPW-1:0] tok_idx, cur_idx;

    assign tok_idx    = bus.rx_token_endpoint[EPW-1:0];
    assign cur_idx    = ep_reg[EPW-1:0];
    assign token_hit  = bus.rx_token_valid && (bus.rx_token_address == bus.device_address)
                        && ({1'b0, bus.rx_token_endpoint} < EP_LIMIT);
    assign rx_is_data = (bus.rx_pid[2:0] == 3'b011);

`ifdef USB_SEQ_STALL_EN
    assign tok_stall = bus.ep_stall[tok_idx];
    assign cur_stall = bus.ep_stall[cur_idx];
`else
    logic unused_stall;
    assign unused_stall = ^bus.ep_stall;
    assign tok_stall    = 1'b0;
    assign cur_stall    = 1'b0;
`endif

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            ep_reg     <= '0;
            is_setup   <= 1'b0;
            tx_pid_reg <= '0;
            with_data  <= 1'b0;
            in_toggle  <= '0;
            out_toggle <= '0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            ep_reg     <= ep_next;
            is_setup   <= is_setup_next;
            tx_pid_reg <= tx_pid_next;
            with_data  <= with_data_next;
            in_toggle  <= in_toggle_next;
            out_toggle <= out_toggle_next;
        end
    end

    always_comb begin
        state_next      = state;
        timer_next      = (timer == T_MAX) ? timer : timer + 1'b1;
        ep_next         = ep_reg;
        is_setup_next   = is_setup;
        tx_pid_next     = tx_pid_reg;
        with_data_next  = with_data;
        in_toggle_next  = in_toggle;
        out_toggle_next = out_toggle;
        resp_valid      = 1'b0;
        resp_pid        = PID_ACK;
        resp_data       = 1'b0;
        tx_start_c      = 1'b0;
        setup_ev        = 1'b0;
        out_ev          = 1'b0;
        in_ev           = 1'b0;
        case (state)
            IDLE, WAIT_DATA: begin
                // Any token aborts a pending OUT/SETUP and is then handled exactly as from IDLE
                if (bus.rx_token_valid) begin
                    state_next = IDLE;
                    if (token_hit && (bus.rx_pid == PID_SETUP || bus.rx_pid == PID_OUT)) begin
                        state_next    = WAIT_DATA;
                        ep_next       = bus.rx_token_endpoint;
                        is_setup_next = (bus.rx_pid == PID_SETUP);
                        timer_next    = '0;
                    end else if (token_hit && bus.rx_pid == PID_IN) begin
                        ep_next    = bus.rx_token_endpoint;
                        resp_valid = 1'b1;
                        if (tok_stall) begin
                            resp_pid = PID_STALL;
                        end else if (!bus.ep_in_ready[tok_idx]) begin
                            resp_pid = PID_NAK;
                        end else begin
                            resp_pid  = in_toggle[tok_idx] ? PID_DATA1 : PID_DATA0;
                            resp_data = 1'b1;
                        end
                    end
                end else if (state == WAIT_DATA) begin
                    if (timer == T_MAX) begin
                        state_next = IDLE;
                    end else if (bus.rx_data_valid) begin
                        state_next = IDLE;
                        if (bus.rx_data_ok && rx_is_data) begin
                            if (is_setup) begin
                                // SETUP must be accepted regardless of halt or buffer state
                                if (!bus.rx_pid[3]) begin
                                    resp_valid               = 1'b1;
                                    setup_ev                 = 1'b1;
                                    in_toggle_next[cur_idx]  = 1'b1;
                                    out_toggle_next[cur_idx] = 1'b1;
                                end
                            end else begin
                                resp_valid = 1'b1;
                                if (cur_stall) begin
                                    resp_pid = PID_STALL;
                                end else if (!bus.ep_out_free[cur_idx]) begin
                                    resp_pid = PID_NAK;
                                end else if (bus.rx_pid[3] == out_toggle[cur_idx]) begin
                                    out_ev                   = 1'b1;
                                    out_toggle_next[cur_idx] = ~out_toggle[cur_idx];
                                end
                            end
                        end
                    end
                end
            end
            SEND_HANDSHAKE, SEND_DATA: begin
                tx_start_c = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.tx_done) begin
                    state_next = with_data ? WAIT_ACK : IDLE;
                    timer_next = '0;
                end
            end
            WAIT_ACK: begin
                if (timer == T_MAX) begin
                    state_next = IDLE;
                end else if (bus.rx_data_valid) begin
                    state_next = IDLE;
                    if (bus.rx_pid == PID_ACK) begin
                        in_ev                   = 1'b1;
                        in_toggle_next[cur_idx] = ~in_toggle[cur_idx];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (resp_valid) begin
            tx_pid_next    = resp_pid;
            with_data_next = resp_data;
            state_next     = resp_data ? SEND_DATA : SEND_HANDSHAKE;
        end
    end

    assign bus.tx_start         = tx_start_c;
    assign bus.tx_pid           = tx_pid_reg;
    assign bus.tx_with_data     = with_data;
    assign bus.current_endpoint = ep_reg;
    assign bus.setup_received   = setup_ev;
    assign bus.out_received     = out_ev;
    assign bus.in_sent          = in_ev;
endmodule

// File: tb/tb_usb_transaction_sequencer.sv
// tb/tb_usb_transaction_sequencer.sv - randomized transaction-level bench for usb_transaction_sequencer
`timescale 1ns/1ps
module tb_usb_transaction_sequencer;
    localparam int NE  = 4;
    localparam int TMO = 72;
    localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_SETUP = 4'b1101;
    localparam logic [3:0] P_DATA0 = 4'b0011, P_DATA1 = 4'b1011;
    localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010, P_STALL = 4'b1110;
`ifdef USB_SEQ_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clock48 = 1'b0;
    logic reset_n;
    always #10 clock48 = ~clock48;

    usb_transaction_sequencer_if #(.NE(NE)) bus ();
    usb_transaction_sequencer #(.NUM_ENDPOINTS(NE), .TIMEOUT_CYCLES(TMO)) dut (
        .clock48(clock48), .reset_n(reset_n), .bus(bus)
    );

    typedef struct { int cyc; logic [3:0] pid; logic wd; logic [3:0] ep; } tx_exp_t;
    typedef struct { int cyc; int kind; logic [3:0] ep; } ev_exp_t;
    tx_exp_t txq[$];
    ev_exp_t evq[$];
    tx_exp_t te;
    ev_exp_t ee;

    int vectors = 0, miscompares = 0, cyc = 0, tx_count = 0, ev_count = 0, nev;
    int last_ev_kind = 0;
    logic [3:0] last_tx_pid = '0;
    logic last_tx_wd = 1'b0;
    bit in_tog [NE];
    bit out_tog [NE];

    always @(posedge clock48) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clock48) begin
        if (reset_n) begin
            nev = int'(bus.setup_received) + int'(bus.out_received) + int'(bus.in_sent);
            check("single_event", 32'(nev <= 1), 32'd1);
            if (nev != 0) begin
                ev_count++;
                last_ev_kind = bus.setup_received ? 1 : (bus.out_received ? 2 : 3);
                if (evq.size() == 0) begin
                    check("unexpected_event", 32'(last_ev_kind), 32'd0);
                end else begin
                    ee = evq.pop_front();
                    check("event_kind", 32'(last_ev_kind), 32'(ee.kind));
                    check("event_cycle", 32'(cyc), 32'(ee.cyc));
                    check("event_ep", 32'(bus.current_endpoint), 32'(ee.ep));
                end
            end else if (evq.size() != 0 && evq[0].cyc <= cyc) begin
                check("missing_event", 32'd0, 32'(evq[0].kind));
                void'(evq.pop_front());
            end
            if (bus.tx_start) begin
                tx_count++;
                last_tx_pid = bus.tx_pid;
                last_tx_wd  = bus.tx_with_data;
                if (txq.size() == 0) begin
                    check("unexpected_tx_start", 32'(bus.tx_pid), 32'hffff);
                end else begin
                    te = txq.pop_front();
                    check("tx_cycle", 32'(cyc), 32'(te.cyc));
                    check("tx_pid", 32'(bus.tx_pid), 32'(te.pid));
                    check("tx_with_data", 32'(bus.tx_with_data), 32'(te.wd));
                    check("tx_ep", 32'(bus.current_endpoint), 32'(te.ep));
                end
            end else if (txq.size() != 0 && txq[0].cyc <= cyc) begin
                check("missing_tx_start", 32'd0, 32'(txq[0].pid));
                void'(txq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock48);
        #1;
    endtask

    task automatic settle();
        repeat (2) tick();
        check("queues_drained", 32'(txq.size() + evq.size()), 32'd0);
        txq.delete();
        evq.delete();
    endtask

    task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input int ep, output int tc);
        bus.rx_pid            = pid;
        bus.rx_token_address  = addr;
        bus.rx_token_endpoint = 4'(ep);
        bus.rx_token_valid    = 1'b1;
        tc = cyc;
        tick();
        bus.rx_token_valid = 1'b0;
    endtask

    task automatic finish_tx(output int td);
        repeat ($urandom_range(1, 4)) tick();
        bus.tx_done = 1'b1;
        td = cyc;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic out_like(input bit setup, input int ep, input logic [6:0] addr,
                            input logic [3:0] dpid, input bit ok, input int delay);
        int tc, dc, td, ev;
        bit hit, resp;
        logic [3:0] rp;
        hit = (addr == bus.device_address) && (ep < NE);
        send_token(setup ? P_SETUP : P_OUT, addr, ep, tc);
        repeat (delay - 1) tick();
        bus.rx_pid = dpid; bus.rx_data_ok = ok; bus.rx_data_valid = 1'b1;
        dc = cyc; resp = 1'b0; ev = 0; rp = P_ACK;
        if (hit && delay <= TMO && ok && (dpid == P_DATA0 || dpid == P_DATA1)) begin
            if (setup) begin
                if (dpid == P_DATA0) begin
                    resp = 1'b1; ev = 1; in_tog[ep] = 1'b1; out_tog[ep] = 1'b1;
                end
            end else if (STALL_EN && bus.ep_stall[ep]) begin
                resp = 1'b1; rp = P_STALL;
            end else if (!bus.ep_out_free[ep]) begin
                resp = 1'b1; rp = P_NAK;
            end else begin
                resp = 1'b1;
                if ((dpid == P_DATA1) == out_tog[ep]) begin
                    ev = 2; out_tog[ep] = !out_tog[ep];
                end
            end
        end
        if (ev != 0) evq.push_back('{dc, ev, 4'(ep)});
        if (resp) txq.push_back('{dc + 1, rp, 1'b0, 4'(ep)});
        tick();
        bus.rx_data_valid = 1'b0;
        if (resp) finish_tx(td);
        settle();
    endtask

    // reply: 0 ACK soon, 1 NAK, 2 silence, 3 ACK at last legal cycle, 4 ACK one cycle late, -1 random
    task automatic in_txn(input int ep, input logic [6:0] addr, input int reply);
        int tc, td, d, r;
        bit hit, data;
        logic [3:0] rp;
        hit = (addr == bus.device_address) && (ep < NE);
        data = 1'b0;
        send_token(P_IN, addr, ep, tc);
        if (hit) begin
            if (STALL_EN && bus.ep_stall[ep]) rp = P_STALL;
            else if (!bus.ep_in_ready[ep]) rp = P_NAK;
            else begin rp = in_tog[ep] ? P_DATA1 : P_DATA0; data = 1'b1; end
            txq.push_back('{tc + 1, rp, data, 4'(ep)});
            finish_tx(td);
        end
        if (data) begin
            r = reply;
            if (r < 0) begin
                r = $urandom_range(0, 9);
                r = (r < 6) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : (r < 9) ? 3 : 4;
            end
            if (r == 2) begin
                repeat (80) tick();
            end else begin
                d = (r == 3) ? TMO : (r == 4) ? TMO + 1 : $urandom_range(1, 10);
                repeat (d - 1) tick();
                bus.rx_pid = (r == 1) ? P_NAK : P_ACK;
                bus.rx_data_ok = 1'b1; bus.rx_data_valid = 1'b1;
                if (r != 1 && d <= TMO) begin
                    evq.push_back('{cyc, 3, 4'(ep)});
                    in_tog[ep] = !in_tog[ep];
                end
                tick();
                bus.rx_data_valid = 1'b0;
            end
        end
        settle();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        for (int i = 0; i < NE; i++) begin in_tog[i] = 1'b0; out_tog[i] = 1'b0; end
        txq.delete();
        evq.delete();
    endtask

    initial begin
        int tc, snap, k, ep, d, r;
        logic [6:0] a;
        logic [3:0] dp;
        bus.device_address = '0; bus.rx_token_valid = 0; bus.rx_pid = '0;
        bus.rx_token_address = '0; bus.rx_token_endpoint = '0; bus.rx_data_valid = 0;
        bus.rx_data_ok = 0; bus.tx_done = 0;
        bus.ep_in_ready = '1; bus.ep_out_free = '1; bus.ep_stall = '0;
        apply_reset();
        repeat (3) @(negedge clock48);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_pid", 32'(bus.tx_pid), 32'd0);
        check("rst_tx_with_data", 32'(bus.tx_with_data), 32'd0);
        check("rst_current_ep", 32'(bus.current_endpoint), 32'd0);
        check("rst_events", 32'({bus.setup_received, bus.out_received, bus.in_sent}), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        out_like(1'b1, 0, 7'd0, P_DATA0, 1'b1, 3);
        check("dir_setup_ack", 32'(last_tx_pid), 32'(4'b0010));
        check("dir_setup_event", 32'(last_ev_kind), 32'd1);
        check("dir_setup_in_toggle", 32'(in_tog[0]), 32'd1);
        in_txn(0, 7'd0, 0);
        check("dir_in_data1", 32'(last_tx_pid), 32'(4'b1011));
        check("dir_in_with_data", 32'(last_tx_wd), 32'd1);
        check("dir_in_sent", 32'(last_ev_kind), 32'd3);
        in_txn(0, 7'd0, 1);
        check("dir_in_next_data0", 32'(last_tx_pid), 32'(4'b0011));
        snap = ev_count;
        out_like(1'b0, 1, 7'd0, P_DATA0, 1'b1, 2);
        out_like(1'b0, 1, 7'd0, P_DATA0, 1'b1, 2);
        check("dir_out_one_event", 32'(ev_count - snap), 32'd1);
        check("dir_out_retx_ack", 32'(last_tx_pid), 32'(4'b0010));
        check("dir_out_toggle", 32'(out_tog[1]), 32'd1);
        bus.ep_in_ready = 4'b1011;
        in_txn(2, 7'd0, 0);
        check("dir_in_nak", 32'(last_tx_pid), 32'(4'b1010));
        bus.ep_in_ready = '1;
        bus.device_address = 7'd1;
        snap = tx_count;
        in_txn(0, 7'd5, 0);
        out_like(1'b0, 1, 7'd1, P_DATA1, 1'b1, 90);
        out_like(1'b0, 1, 7'd1, P_DATA1, 1'b0, 4);
        check("dir_silent", 32'(tx_count - snap), 32'd0);
        out_like(1'b0, 1, 7'd1, P_DATA1, 1'b1, TMO);
        out_like(1'b0, 1, 7'd1, P_DATA0, 1'b1, TMO + 1);
        bus.ep_stall = 4'b0010;
        in_txn(1, 7'd1, 0);
        check("dir_stall_in", 32'(last_tx_pid), 32'(STALL_EN ? P_STALL : P_DATA0));
        out_like(1'b1, 1, 7'd1, P_DATA0, 1'b1, 5);
        check("dir_stall_setup_ack", 32'(last_tx_pid), 32'(P_ACK));
        bus.ep_stall = '0;
        send_token(P_OUT, 7'd1, 1, tc);
        repeat (2) tick();
        in_txn(2, 7'd1, 3);
        in_txn(2, 7'd1, 4);

        // Reset while the transmitter is busy: no re-issue of tx_start, toggles back to DATA0
        out_like(1'b1, 0, 7'd1, P_DATA0, 1'b1, 1);
        send_token(P_IN, 7'd1, 0, tc);
        txq.push_back('{tc + 1, P_DATA1, 1'b1, 4'd0});
        repeat (3) tick();
        snap = tx_count;
        apply_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("rst_no_reissue", 32'(tx_count - snap), 32'd0);
        in_txn(0, 7'd1, 0);
        check("rst_toggle_data0", 32'(last_tx_pid), 32'(4'b0011));

        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 9);
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 3);
                bus.device_address = (r == 0) ? 7'd0 : (r == 1) ? 7'd1 : (r == 2) ? 7'd5 : 7'd127;
            end
            bus.ep_in_ready = 4'($urandom);
            bus.ep_out_free = 4'($urandom) | 4'($urandom);
            bus.ep_stall = 4'($urandom) & 4'($urandom);
            a = ($urandom_range(0, 4) == 0) ? (bus.device_address ^ 7'($urandom_range(1, 127)))
                                             : bus.device_address;
            ep = (k == 8) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            r = $urandom_range(0, 19);
            d = (r < 17) ? $urandom_range(1, 20) : (r == 17) ? TMO : (r == 18) ? TMO + 1 : 90;
            if (k == 3) dp = ($urandom_range(0, 4) == 0) ? P_DATA1 : P_DATA0;
            else dp = $urandom_range(0, 1) ? P_DATA1 : P_DATA0;
            if (k <= 2 || k == 8) out_like(1'b0, ep, a, dp, $urandom_range(0, 9) != 0, d);
            else if (k == 3) out_like(1'b1, ep, a, dp, $urandom_range(0, 9) != 0, d);
            else if (k <= 6) in_txn(ep, a, -1);
            else begin
                send_token(P_ACK, a, ep, tc);
                settle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
